// File: rtl/result_collector_if.sv
// Handshake bundle between the arithmetic units, a requester and the result consumer.
// The requester/test side drives through master; the collector sits on slave.
interface result_collector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic                    start;
  logic [1:0]              op_sel;
  logic signed [WIDTH-1:0] addsub_res;
  logic                    addsub_ovf;
  logic                    addsub_valid;
  logic signed [WIDTH-1:0] muldiv_res;
  logic                    muldiv_err;
  logic                    muldiv_valid;
  logic                    out_ready;
  logic                    clr_sticky;
  logic                    busy;
  logic                    out_valid;
  logic signed [WIDTH-1:0] sel_res;
  logic                    ovf_flag;
  logic                    muldiv_err_flag;
  logic                    timeout_flag;
  logic                    sticky_ovf;
  logic                    sticky_err;
  logic [CNT_W-1:0]        op_count;

  modport master (
    output start, op_sel, addsub_res, addsub_ovf, addsub_valid,
           muldiv_res, muldiv_err, muldiv_valid, out_ready, clr_sticky,
    input  busy, out_valid, sel_res, ovf_flag, muldiv_err_flag,
           timeout_flag, sticky_ovf, sticky_err, op_count
  );

  modport slave (
    input  start, op_sel, addsub_res, addsub_ovf, addsub_valid,
           muldiv_res, muldiv_err, muldiv_valid, out_ready, clr_sticky,
    output busy, out_valid, sel_res, ovf_flag, muldiv_err_flag,
           timeout_flag, sticky_ovf, sticky_err, op_count
  );
endinterface

// File: rtl/result_collector.sv
// Registers the selected arithmetic unit's result; start-to-out_valid is 2 cycles minimum,
// TIMEOUT+1 on abort. The result is held in HOLD until out_ready; start is ignored unless IDLE.
module result_collector #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  result_collector_if.slave bus
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [1:0]              op_q;
  logic [TMR_W-1:0]        timer;
  logic signed [WIDTH-1:0] sel_res_q;
  logic                    ovf_q;
  logic                    err_q;
  logic                    tmo_q;
  logic                    sticky_ovf_q;
  logic                    sticky_err_q;
  logic [CNT_W-1:0]        count_q;

  logic is_muldiv;
  logic sel_vld;
  logic accept;
  logic take;
  logic abort;
  logic tick;
  logic handoff;

  // op_q[1] distinguishes mul/div (10, 11) from add/sub (00, 01)
  assign is_muldiv = op_q[1];
  assign sel_vld   = is_muldiv ? bus.muldiv_valid : bus.addsub_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take      = 1'b0;
    abort     = 1'b0;
    tick      = 1'b0;
    handoff   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // a valid in the timer's last cycle still wins over the abort
        if (sel_vld) begin
          take      = 1'b1;
          state_nxt = S_HOLD;
        end else if (timer == TMR_MAX) begin
          abort     = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          tick = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          handoff   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 2'b00;
      timer        <= '0;
      sel_res_q    <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_err_q <= 1'b0;
      count_q      <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.op_sel;
        timer <= '0;
      end else if (tick) begin
        timer <= timer + TMR_W'(1);
      end

      if (take) begin
        sel_res_q <= is_muldiv ? bus.muldiv_res : bus.addsub_res;
        ovf_q     <= ~is_muldiv & bus.addsub_ovf;
        err_q     <= is_muldiv & bus.muldiv_err;
        tmo_q     <= 1'b0;
      end else if (abort) begin
        sel_res_q <= '0;
        ovf_q     <= 1'b0;
        err_q     <= 1'b0;
        tmo_q     <= 1'b1;
      end

      if (handoff) count_q <= count_q + CNT_W'(1);

      // clear is applied first so a same-cycle handoff event survives
      sticky_ovf_q <= (sticky_ovf_q & ~bus.clr_sticky) | (handoff & ovf_q);
      sticky_err_q <= (sticky_err_q & ~bus.clr_sticky) | (handoff & (err_q | tmo_q));
    end
  end

  assign bus.busy            = (state == S_WAIT);
  assign bus.out_valid       = (state == S_HOLD);
  assign bus.sel_res         = sel_res_q;
  assign bus.ovf_flag        = ovf_q;
  assign bus.muldiv_err_flag = err_q;
  assign bus.timeout_flag    = tmo_q;
  assign bus.sticky_ovf      = sticky_ovf_q;
  assign bus.sticky_err      = sticky_err_q;
  assign bus.op_count        = count_q;

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Registered, handshaked successor to the calculator's combinational result selector.
- On start, captures the requested operation and waits for the matching arithmetic unit to report valid: add/sub or mul/div (multi-cycle).
- Registers the signed result with per-operation flags and holds it with a valid/ready handshake toward display/output logic.
- Maintains sticky overflow/error flags and a response timeout for the multi-cycle unit.

Parameters:
- WIDTH, 8, result width in bits (signed two's complement); legal ≥ 2.
- TIMEOUT, 32, maximum cycles to wait for unit valid after start before aborting; legal ≥ 1.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- op_sel  in  2  00 add, 01 sub, 10 mul, 11 div; sampled with accepted start.
- addsub_res  in  WIDTH  signed add/sub result.
- addsub_ovf  in  1  add/sub overflow.
- addsub_valid  in  1  add/sub result valid this cycle.
- muldiv_res  in  WIDTH  signed mul/div result.
- muldiv_err  in  1  mul/div error (overflow or divide by zero).
- muldiv_valid  in  1  mul/div result valid this cycle.
- out_ready  in  1  consumer accepts result.
- clr_sticky  in  1  clears sticky flags.
- busy  out  1  high in WAIT.
- out_valid  out  1  result held for consumer (HOLD).
- sel_res  out  WIDTH  registered signed result.
- ovf_flag  out  1  registered add/sub overflow for this result.
- muldiv_err_flag  out  1  registered mul/div error for this result.
- timeout_flag  out  1  this result was aborted by timeout.
- sticky_ovf  out  1  OR of all ovf_flag since last clear.
- sticky_err  out  1  OR of all muldiv_err_flag and timeout_flag since last clear.
- op_count  out  CNT_W  number of results handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any state): state IDLE.
  - All outputs 0, including sel_res = 0, op_count = 0, sticky flags 0.
  - Internal op register = 00; timer = 0.
- IDLE:
  - start=1 → capture op_sel, clear timer, go WAIT next edge.
  - Unit valids are ignored in IDLE.
- WAIT (busy=1):
  - Selects the unit by the captured op: 00/01 use add/sub inputs; 10/11 use mul/div inputs.
  - Only the selected unit's valid counts; the other unit's valid is ignored.
  - On selected valid:
    - Register sel_res from the selected unit.
    - add/sub: ovf_flag = addsub_ovf, muldiv_err_flag = 0.
    - mul/div: muldiv_err_flag = muldiv_err, ovf_flag = 0.
    - timeout_flag = 0; go HOLD.
  - Valid arriving in the first WAIT cycle is legal; minimum start-to-out_valid latency is 2 cycles.
  - Timer increments each WAIT cycle without valid. When timer reaches TIMEOUT-1 with no valid:
    - Next edge: sel_res = 0, ovf_flag = 0, muldiv_err_flag = 0, timeout_flag = 1; go HOLD.
    - Valid and timeout in the same cycle: valid wins.
  - start in WAIT is ignored.
- HOLD (out_valid=1):
  - sel_res and all flags are stable.
  - out_ready=1 → handoff:
    - op_count += 1.
    - sticky_ovf |= ovf_flag; sticky_err |= muldiv_err_flag | timeout_flag.
    - Go IDLE next edge; out_valid drops that edge.
    - sel_res and flags keep their last value in IDLE.
  - start in HOLD is ignored, including a start in the same cycle as the handoff.
- clr_sticky:
  - Clears both sticky flags next edge.
  - Same cycle as a handoff setting a sticky bit: set wins (the new event is not lost).
- Arithmetic: pure selection, no width conversion; both unit results are already WIDTH-bit signed.
- Illegal state encodings recover to IDLE.

Test Plan:
- Reset, then start with op_sel=00 and addsub_valid=1, addsub_res=8'sh05, addsub_ovf=0 in the WAIT cycle → out_valid after 2 cycles, sel_res=5, flags 0; out_ready=1 → op_count=1, back to IDLE.
- op_sel=01, addsub_res=8'sh80, addsub_ovf=1; hold out_ready=0 for 5 cycles → outputs stable for all 5 cycles; on accept, sticky_ovf=1.
- op_sel=11, muldiv_valid after 6 cycles with muldiv_err=1, res=0; addsub_valid pulsed during WAIT → add/sub pulse ignored; muldiv_err_flag=1, ovf_flag=0; on accept, sticky_err=1.
- op_sel=10, no muldiv_valid, TIMEOUT=32 → out_valid exactly TIMEOUT+1 cycles after start, timeout_flag=1, sel_res=0; on accept, sticky_err=1.
- clr_sticky asserted in the same cycle as an accept with ovf_flag=1 → sticky_ovf remains 1; clr_sticky alone next cycle → 0.
- Assert rst mid-WAIT, then run 256 handoffs with CNT_W=8 → immediate IDLE with all outputs 0; op_count wraps to 0.
